// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 16x16 datapath register file.
package reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef reg_data_t [NUM_REGS-1:0] reg_array_t;

  localparam reg_data_t REG_RESET_VAL = '0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file bus: decode addresses, writeback strobe/data, execute operands.
interface reg_file_if;
  import reg_file_pkg::*;

  reg_addr_t src1;
  reg_addr_t src2;
  reg_addr_t dest;
  reg_data_t writeVal;
  logic      writeEn;
  logic      readEn;
  reg_data_t reg1;
  reg_data_t reg2;

  // master = pipeline side driving the file, slave = the register file itself
  modport master (
    output src1, src2, dest, writeVal, writeEn, readEn,
    input  reg1, reg2
  );

  modport slave (
    input  src1, src2, dest, writeVal, writeEn, readEn,
    output reg1, reg2
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port: address mux, optional write-first bypass, readEn-gated output flop.
// Build option: define REG_FILE_BYPASS_EN for write-first same-cycle reads.
module reg_file_rd_port
  import reg_file_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  reg_array_t mem,
  input  reg_addr_t  src,
  input  reg_addr_t  dest,
  input  reg_data_t  writeVal,
  input  logic       writeEn,
  input  logic       readEn,
  output reg_data_t  rd_data
);

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic      hit;
  reg_data_t rd_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_next = mem[src];
    hit     = BYPASS && writeEn && (dest == src);
    if (hit) rd_next = writeVal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rd_data <= REG_RESET_VAL;
    else if (readEn) rd_data <= rd_next;
  end

endmodule

// File: rtl/reg_file.sv
// 16x16 register file, one write port and two registered read ports.
// Build option: define REG_FILE_BYPASS_EN for write-first same-cycle reads.
module reg_file
  import reg_file_pkg::*;
(
  input logic        clk,
  input logic        rst,
  reg_file_if.slave  bus
);

  reg_array_t mem;

  // NOTE: the array is reset because software relies on all registers starting at zero;
  // this keeps it in flops rather than a RAM macro, which has no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= {NUM_REGS{REG_RESET_VAL}};
    end else if (bus.writeEn) begin
      // NOTE: state is updated with <= so both read ports still see the pre-edge array.
      mem[bus.dest] <= bus.writeVal;
    end
  end

  reg_file_rd_port u_rd1 (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem),
    .src      (bus.src1),
    .dest     (bus.dest),
    .writeVal (bus.writeVal),
    .writeEn  (bus.writeEn),
    .readEn   (bus.readEn),
    .rd_data  (bus.reg1)
  );

  reg_file_rd_port u_rd2 (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem),
    .src      (bus.src2),
    .dest     (bus.dest),
    .writeVal (bus.writeVal),
    .writeEn  (bus.writeEn),
    .readEn   (bus.readEn),
    .rd_data  (bus.reg2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, sweep, async reset, random vs model.
module tb_reg_file;
  import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a plain array plus the two expected operand values.
  reg_data_t model_mem [NUM_REGS];
  reg_data_t exp1;
  reg_data_t exp2;

  typedef struct {
    logic      we;
    reg_addr_t dest;
    reg_data_t wv;
    logic      re;
    reg_addr_t s1;
    reg_addr_t s2;
    reg_data_t e1;
    reg_data_t e2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input reg_data_t act, input reg_data_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic we, input reg_addr_t dest, input reg_data_t wv,
                       input logic re, input reg_addr_t s1, input reg_addr_t s2);
    bus.writeEn  = we;
    bus.dest     = dest;
    bus.writeVal = wv;
    bus.readEn   = re;
    bus.src1     = s1;
    bus.src2     = s2;
  endtask

  // Advance the model by one cycle of the currently driven inputs, then clock the DUT.
  task automatic step();
    if (bus.readEn) begin
      exp1 = (BYP && bus.writeEn && bus.dest == bus.src1) ? bus.writeVal : model_mem[bus.src1];
      exp2 = (BYP && bus.writeEn && bus.dest == bus.src2) ? bus.writeVal : model_mem[bus.src2];
    end
    if (bus.writeEn) model_mem[bus.dest] = bus.writeVal;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reg_data_t same_cycle;
    same_cycle = BYP ? 16'hBEEF : 16'h1234;

    //            we   dest   wv        re   s1     s2     e1          e2
    vecs[0] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0,  4'd15, 16'h0000,  16'h0000};
    vecs[1] = '{1'b1, 4'd0, 16'h00E7, 1'b0, 4'd0,  4'd15, 16'h0000,  16'h0000};
    vecs[2] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0,  4'd1,  16'h00E7,  16'h0000};
    vecs[3] = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0,  4'd1,  16'h00E7,  16'h0000};
    vecs[4] = '{1'b1, 4'd3, 16'hBEEF, 1'b1, 4'd3,  4'd0,  same_cycle, 16'h00E7};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd3,  4'd3,  16'hBEEF,  16'hBEEF};
    vecs[6] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0,  4'd0,  16'h00E7,  16'h00E7};
    vecs[7] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd5,  4'd9,  16'h00E7,  16'h00E7};

    foreach (model_mem[i]) model_mem[i] = '0;
    exp1 = '0;
    exp2 = '0;

    // Power-on reset with a read request pending: outputs must stay cleared.
    rst = 1'b1;
    drive(1'b1, 4'd7, 16'hFFFF, 1'b1, 4'd0, 4'd15);
    #1;
    check("por_reg1", bus.reg1, 16'h0000);
    check("por_reg2", bus.reg2, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);

    // Directed vectors; the model is stepped too so it stays aligned.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].dest, vecs[i].wv, vecs[i].re, vecs[i].s1, vecs[i].s2);
      step();
      check($sformatf("vec%0d_reg1", i), bus.reg1, vecs[i].e1);
      check($sformatf("vec%0d_reg2", i), bus.reg2, vecs[i].e2);
    end

    // Register 7 must still be zero: the write during reset was ignored.
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 4'd7);
    step();
    check("rst_write_ignored", bus.reg1, 16'h0000);

    // Full sweep: distinct value per register, read back in mirrored pairs.
    for (int i = 0; i < NUM_REGS; i++) begin
      drive(1'b1, reg_addr_t'(i), reg_data_t'(16'hA500 + i), 1'b0, 4'd0, 4'd0);
      step();
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      drive(1'b0, 4'd0, 16'h0000, 1'b1, reg_addr_t'(i), reg_addr_t'(15 - i));
      step();
      check($sformatf("sweep%0d_reg1", i), bus.reg1, reg_data_t'(16'hA500 + i));
      check($sformatf("sweep%0d_reg2", i), bus.reg2, reg_data_t'(16'hA50F - i));
    end

    // Asynchronous reset between edges: outputs clear before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_reg1", bus.reg1, 16'h0000);
    check("async_rst_reg2", bus.reg2, 16'h0000);
    drive(1'b1, 4'd4, 16'hFFFF, 1'b1, 4'd4, 4'd4);
    @(posedge clk);
    #1;
    check("rst_hold_reg1", bus.reg1, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (model_mem[i]) model_mem[i] = '0;
    exp1 = '0;
    exp2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      drive(1'b0, 4'd0, 16'h0000, 1'b1, reg_addr_t'(i), reg_addr_t'(15 - i));
      step();
      check($sformatf("post_rst%0d_reg1", i), bus.reg1, 16'h0000);
      check($sformatf("post_rst%0d_reg2", i), bus.reg2, 16'h0000);
    end

    // Random traffic with frequent same-address collisions, checked against the model.
    for (int n = 0; n < 500; n++) begin
      reg_addr_t s1, s2, d;
      s1 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      s2 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      d  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      if ($urandom_range(0, 3) == 0) d = s1;
      else if ($urandom_range(0, 3) == 0) d = s2;
      drive(logic'($urandom_range(0, 1)), d, reg_data_t'($urandom),
            logic'($urandom_range(0, 1)), s1, s2);
      step();
      check($sformatf("rand%0d_reg1", n), bus.reg1, exp1);
      check($sformatf("rand%0d_reg2", n), bus.reg2, exp2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
